baccarat_ctrl: RTL and testbench

Sequencing controller for the baccarat hand datapath: card registers, score adders and the per-card seven-segment decoders. Driven by the one-step-per-press slow clock, it emits one card-load strobe per cycle in dealing order. After the two-card deal it applies the player and dealer third-card rules to the live scores. It then latches the winner lights and holds until reset.

---
 rtl/baccarat_pkg.sv | 42 ++++
 rtl/dealer_draw_rule.sv | 34 +++
 rtl/baccarat_ctrl.sv | 93 +++++++++
 tb/tb_baccarat_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : baccarat_pkg
//  Purpose  : Shared state encoding, card constants and card-value helper
//             for the baccarat hand controller.
//  Revision : 1.0  initial release
// ============================================================================
package baccarat_pkg;

    typedef logic [3:0] state_t;

    localparam state_t DEAL_P1  = 4'd0;
    localparam state_t DEAL_D1  = 4'd1;
    localparam state_t DEAL_P2  = 4'd2;
    localparam state_t DEAL_D2  = 4'd3;
    localparam state_t DECIDE_P = 4'd4;
    localparam state_t DRAW_P3  = 4'd5;
    localparam state_t DECIDE_D = 4'd6;
    localparam state_t DRAW_D3  = 4'd7;
    localparam state_t RESULT   = 4'd8;
    localparam state_t DONE     = 4'd9;

    localparam logic [3:0] CARD_BLANK       = 4'd0;
    localparam logic [3:0] CARD_ACE         = 4'd1;
    localparam logic [3:0] CARD_TEN         = 4'd10;
    localparam logic [3:0] CARD_KING        = 4'd13;
    localparam logic [3:0] NATURAL_MIN      = 4'd8;
    localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;

    // Tens, face cards, blanks and out-of-range codes all score zero.
    function automatic logic [3:0] card_value(input logic [3:0] card);
        if (card == CARD_BLANK || card > CARD_KING || card >= CARD_TEN)
            return 4'd0;
        else if (card >= CARD_ACE)
            return card;
        else
            return 4'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dealer_draw_rule.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : dealer_draw_rule
//  Purpose  : Combinational dealer third-card decision from the dealer score
//             and the player's raw third card.
//  Revision : 1.0  initial release
// ============================================================================
module dealer_draw_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] i_dscore,
    input  logic [3:0] i_pcard3,
    output logic       o_draw
);

    logic [3:0] w_value;

    assign w_value = card_value(i_pcard3);

    always_comb begin
        o_draw = 1'b0;
        case (i_dscore)
            4'd0, 4'd1, 4'd2: o_draw = 1'b1;
            4'd3:             o_draw = (w_value != 4'd8);
            4'd4:             o_draw = (w_value >= 4'd2) && (w_value <= 4'd7);
            4'd5:             o_draw = (w_value >= 4'd4) && (w_value <= 4'd7);
            4'd6:             o_draw = (w_value == 4'd6) || (w_value == 4'd7);
            default:          o_draw = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/baccarat_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : baccarat_ctrl
//  Purpose  : Deals cards in order, applies third-card rules to the live
//             scores, then latches the winner lights until reset.
//  Revision : 1.0  initial release
// ============================================================================
module baccarat_ctrl
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       reset,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light
);

    state_t r_state;
    state_t w_next_state;
    logic   w_dealer_draw;
    logic   r_player_win;
    logic   r_dealer_win;

    dealer_draw_rule u_dealer_draw_rule (
        .i_dscore (dscore),
        .i_pcard3 (pcard3),
        .o_draw   (w_dealer_draw)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DEAL_P1:  w_next_state = DEAL_D1;
            DEAL_D1:  w_next_state = DEAL_P2;
            DEAL_P2:  w_next_state = DEAL_D2;
            DEAL_D2:  w_next_state = DECIDE_P;
            DECIDE_P: begin
                if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN)
                    w_next_state = RESULT;
                else if (pscore < PLAYER_STAND_MIN)
                    w_next_state = DRAW_P3;
                else if (dscore < PLAYER_STAND_MIN)
                    w_next_state = DRAW_D3;
                else
                    w_next_state = RESULT;
            end
            DRAW_P3:  w_next_state = DECIDE_D;
            DECIDE_D: w_next_state = w_dealer_draw ? DRAW_D3 : RESULT;
            DRAW_D3:  w_next_state = RESULT;
            RESULT:   w_next_state = DONE;
            DONE:     w_next_state = DONE;
            default:  w_next_state = DEAL_P1;
        endcase
    end

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset)
            r_state <= DEAL_P1;
        else
            r_state <= w_next_state;
    end

    // Lights move only on the RESULT->DONE edge; a tie lights both.
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            r_player_win <= 1'b0;
            r_dealer_win <= 1'b0;
        end else if (r_state == RESULT) begin
            r_player_win <= (pscore >= dscore);
            r_dealer_win <= (dscore >= pscore);
        end
    end

    assign load_pcard1      = (r_state == DEAL_P1);
    assign load_dcard1      = (r_state == DEAL_D1);
    assign load_pcard2      = (r_state == DEAL_P2);
    assign load_dcard2      = (r_state == DEAL_D2);
    assign load_pcard3      = (r_state == DRAW_P3);
    assign load_dcard3      = (r_state == DRAW_D3);
    assign player_win_light = r_player_win;
    assign dealer_win_light = r_dealer_win;

endmodule
`default_nettype wire

// File: tb/tb_baccarat_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_baccarat_ctrl
//  Purpose  : Self-checking bench for baccarat_ctrl: directed hand table,
//             mid-hand reset, dealer-rule sweep and randomized hands.
//  Revision : 1.0  initial release
// ============================================================================
module tb_baccarat_ctrl;

    logic       slow_clock;
    logic       reset;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light;

    baccarat_ctrl dut (
        .slow_clock       (slow_clock),
        .reset            (reset),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light)
    );

    initial begin
        slow_clock = 1'b0;
        forever #5 slow_clock = ~slow_clock;
    end

    // Observed vector: {p1, p2, p3, d1, d2, d3, player_win, dealer_win}
    localparam logic [7:0] E_P1   = 8'b1000_0000;
    localparam logic [7:0] E_P2   = 8'b0100_0000;
    localparam logic [7:0] E_P3   = 8'b0010_0000;
    localparam logic [7:0] E_D1   = 8'b0001_0000;
    localparam logic [7:0] E_D2   = 8'b0000_1000;
    localparam logic [7:0] E_D3   = 8'b0000_0100;
    localparam logic [7:0] E_NONE = 8'b0000_0000;

    typedef struct {
        logic [7:0] out;
        logic [3:0] ps;
        logic [3:0] ds;
    } step_t;

    typedef struct {
        logic [3:0] p0, d0, c, p1, d1;
        int         len;
        logic [1:0] lights;
        int         n_p3;
        int         n_d3;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [7:0] obs();
        return {load_pcard1, load_pcard2, load_pcard3,
                load_dcard1, load_dcard2, load_dcard3,
                player_win_light, dealer_win_light};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Dealer third-card rule expressed as allowed value ranges per dealer score.
    function automatic logic ref_draw(input logic [3:0] d, input logic [3:0] c);
        int v;
        v = (c >= 1 && c <= 9) ? int'(c) : 0;
        if (d >= 7)      return 1'b0;
        else if (d == 6) return (v == 6 || v == 7);
        else if (d == 5) return (v >= 4 && v <= 7);
        else if (d == 4) return (v >= 2 && v <= 7);
        else if (d == 3) return (v != 8);
        else             return 1'b1;
    endfunction

    task automatic do_reset();
        @(negedge slow_clock);
        reset = 1'b1;
        #1;
        check("reset_outputs", {24'd0, obs()}, {24'd0, E_P1});
        @(posedge slow_clock);
        @(negedge slow_clock);
        reset = 1'b0;
    endtask

    task automatic run_model_hand(input bit with_reset, input logic [3:0] p0, input logic [3:0] d0,
                                  input logic [3:0] c, input logic [3:0] p1, input logic [3:0] d1);
        step_t      q[$];
        logic [3:0] fp, fd;
        logic [7:0] exp_done;
        q.push_back('{E_P1, p0, d0});
        q.push_back('{E_D1, p0, d0});
        q.push_back('{E_P2, p0, d0});
        q.push_back('{E_D2, p0, d0});
        q.push_back('{E_NONE, p0, d0});
        fp = p0;
        fd = d0;
        if (p0 >= 8 || d0 >= 8) begin
            fp = p0;
        end else if (p0 <= 5) begin
            q.push_back('{E_P3, p0, d0});
            q.push_back('{E_NONE, p1, d0});
            fp = p1;
            if (ref_draw(d0, c)) begin
                q.push_back('{E_D3, p1, d0});
                fd = d1;
            end
        end else if (d0 <= 5) begin
            q.push_back('{E_D3, p0, d0});
            fd = d1;
        end
        q.push_back('{E_NONE, fp, fd});
        exp_done = {6'b0, (fp >= fd), (fd >= fp)};

        pcard3 = c;
        if (with_reset) do_reset();
        foreach (q[i]) begin
            pscore = q[i].ps;
            dscore = q[i].ds;
            #1;
            check($sformatf("hand p%0d d%0d c%0d cyc%0d", p0, d0, c, i), {24'd0, obs()}, {24'd0, q[i].out});
            @(posedge slow_clock);
            @(negedge slow_clock);
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            check($sformatf("done p%0d d%0d c%0d hold%0d", p0, d0, c, k), {24'd0, obs()}, {24'd0, exp_done});
            @(posedge slow_clock);
            @(negedge slow_clock);
        end
    endtask

    task automatic run_table(input int idx, input vec_t v);
        int         edges, np3, nd3, multi;
        logic [7:0] o;
        bit         saw_p3, saw_d3;
        edges = 0; np3 = 0; nd3 = 0; multi = 0;
        pcard3 = v.c;
        pscore = v.p0;
        dscore = v.d0;
        do_reset();
        o = obs();
        while (edges < 16) begin
            #1;
            o = obs();
            if (o[1:0] != 2'b00) break;
            if ($countones(o[7:2]) > 1) multi++;
            saw_p3 = o[5];
            saw_d3 = o[2];
            if (saw_p3) np3++;
            if (saw_d3) nd3++;
            @(posedge slow_clock);
            edges++;
            @(negedge slow_clock);
            if (saw_p3) pscore = v.p1;
            if (saw_d3) dscore = v.d1;
        end
        check($sformatf("tbl%0d edges_to_done", idx), edges, v.len);
        check($sformatf("tbl%0d lights", idx), {30'd0, o[1:0]}, {30'd0, v.lights});
        check($sformatf("tbl%0d pcard3_loads", idx), np3, v.n_p3);
        check($sformatf("tbl%0d dcard3_loads", idx), nd3, v.n_d3);
        check($sformatf("tbl%0d multi_strobe", idx), multi, 0);
    endtask

    vec_t       tbl [8];
    logic [3:0] rp0, rd0, rc, rp1, rd1;

    initial begin
        reset  = 1'b1;
        pscore = 4'd0;
        dscore = 4'd0;
        pcard3 = 4'd0;
        #1;
        check("power_on_reset", {24'd0, obs()}, {24'd0, E_P1});

        tbl[0] = '{4'd9,  4'd3,  4'd0,  4'd9, 4'd3,  6, 2'b10, 0, 0};
        tbl[1] = '{4'd6,  4'd6,  4'd0,  4'd6, 4'd6,  6, 2'b11, 0, 0};
        tbl[2] = '{4'd4,  4'd6,  4'd8,  4'd2, 4'd6,  8, 2'b01, 1, 0};
        tbl[3] = '{4'd5,  4'd3,  4'd12, 4'd5, 4'd8,  9, 2'b01, 1, 1};
        tbl[4] = '{4'd7,  4'd5,  4'd0,  4'd7, 4'd7,  7, 2'b11, 0, 1};
        tbl[5] = '{4'd12, 4'd2,  4'd0,  4'd12, 4'd2, 6, 2'b10, 0, 0};
        tbl[6] = '{4'd3,  4'd15, 4'd0,  4'd3, 4'd15, 6, 2'b01, 0, 0};
        tbl[7] = '{4'd0,  4'd0,  4'd0,  4'd0, 4'd0,  9, 2'b11, 1, 1};
        for (int i = 0; i < 8; i++) run_table(i, tbl[i]);

        // Reset asserted asynchronously while in DRAW_P3.
        pscore = 4'd2; dscore = 4'd4; pcard3 = 4'd5;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge slow_clock);
            @(negedge slow_clock);
        end
        #1;
        check("pre_reset_in_draw_p3", {24'd0, obs()}, {24'd0, E_P3});
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_mid_hand", {24'd0, obs()}, {24'd0, E_P1});
        @(posedge slow_clock);
        #1;
        check("reset_held_across_edge", {24'd0, obs()}, {24'd0, E_P1});
        @(negedge slow_clock);
        reset = 1'b0;
        run_model_hand(1'b0, 4'd2, 4'd4, 4'd5, 4'd7, 4'd4);

        // Dealer rule sweep through DECIDE_D.
        for (int d = 0; d < 8; d++) begin
            for (int c = 0; c < 16; c++) begin
                run_model_hand(1'b1, 4'd3, 4'(d), 4'(c), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
            end
        end

        for (int h = 0; h < 150; h++) begin
            if ($urandom_range(0, 4) == 0) begin
                rp0 = 4'($urandom_range(0, 15));
                rd0 = 4'($urandom_range(0, 15));
            end else begin
                rp0 = 4'($urandom_range(0, 9));
                rd0 = 4'($urandom_range(0, 9));
            end
            rc  = 4'($urandom_range(0, 15));
            rp1 = 4'($urandom_range(0, 9));
            rd1 = 4'($urandom_range(0, 9));
            run_model_hand(1'b1, rp0, rd0, rc, rp1, rd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
